// File: rtl/if_id_decode_stage_pkg.sv
// Shared encodings for the fetch/decode boundary.
// Opcodes, extender selects, result/ALU selects and the bubble word.
package if_id_decode_stage_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ASRC_RS1  = 2'b00;
   localparam logic [1:0] ASRC_PC   = 2'b01;
   localparam logic [1:0] ASRC_ZERO = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [2:0] immsrc;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic       memwrite;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       alusrc;
      logic [1:0] alusrca;
      logic [1:0] aluop;
      logic       known;
   } ctrl_t;

endpackage

// File: rtl/if_id_decode_stage_main_decoder.sv
// Main decoder: opcode to raw control bundle.
// Purely combinational; validity gating happens in the stage.
module if_id_decode_stage_main_decoder
   import if_id_decode_stage_pkg::*;
(
   input  logic [6:0] opcode_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      ctrl_o.known = 1'b1;
      case (opcode_i)
         OP_LOAD: begin
            ctrl_o.regwrite  = 1'b1;
            ctrl_o.resultsrc = RESULT_MEM;
            ctrl_o.alusrc    = 1'b1;
         end
         OP_STORE: begin
            ctrl_o.immsrc   = IMM_S;
            ctrl_o.memwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
         end
         OP_R: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.aluop    = ALUOP_FUNCT;
         end
         OP_I: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALUOP_FUNCT;
         end
         OP_BRANCH: begin
            ctrl_o.immsrc = IMM_B;
            ctrl_o.branch = 1'b1;
            ctrl_o.aluop  = ALUOP_SUB;
         end
         OP_JAL: begin
            ctrl_o.immsrc    = IMM_J;
            ctrl_o.regwrite  = 1'b1;
            ctrl_o.jump      = 1'b1;
            ctrl_o.resultsrc = RESULT_PC4;
         end
         OP_JALR: begin
            ctrl_o.regwrite  = 1'b1;
            ctrl_o.jump      = 1'b1;
            ctrl_o.jalr      = 1'b1;
            ctrl_o.alusrc    = 1'b1;
            ctrl_o.resultsrc = RESULT_PC4;
         end
         OP_LUI: begin
            ctrl_o.immsrc   = IMM_U;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.alusrca  = ASRC_ZERO;
         end
         OP_AUIPC: begin
            ctrl_o.immsrc   = IMM_U;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.alusrca  = ASRC_PC;
         end
         default: ctrl_o.known = 1'b0;
      endcase
   end

endmodule

// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline register with stall/flush plus D-stage decode.
// Architectural side effects are gated off for bubbles and illegal slots.
module if_id_decode_stage
   import if_id_decode_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter logic [31:0] NOP  = NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instrF,
   input  logic [XLEN-1:0] pcF,
   input  logic [XLEN-1:0] pcplus4F,
   input  logic            validF,
   input  logic            stallD,
   input  logic            flushD,
   output logic [31:0]     instrD,
   output logic [XLEN-1:0] pcD,
   output logic [XLEN-1:0] pcplus4D,
   output logic            validD,
   output logic [2:0]      immsrcD,
   output logic            regwriteD,
   output logic [1:0]      resultsrcD,
   output logic            memwriteD,
   output logic            branchD,
   output logic            jumpD,
   output logic            jalrD,
   output logic            alusrcD,
   output logic [1:0]      alusrcaD,
   output logic [1:0]      aluopD,
   output logic [4:0]      rs1D,
   output logic [4:0]      rs2D,
   output logic [4:0]      rdD,
   output logic            illegalD,
   output logic            illegal_seen
);

   logic [31:0]     instr_q;
   logic [XLEN-1:0] pc_q, pcp4_q;
   logic            valid_q, seen_q;
   logic            seen_d, live;
   ctrl_t           ctrl;

   always_ff @(posedge clk) begin
      if (reset || flushD) begin
         instr_q <= NOP;
         pc_q    <= '0;
         pcp4_q  <= '0;
         valid_q <= 1'b0;
      end else if (!stallD) begin
         instr_q <= instrF;
         pc_q    <= pcF;
         pcp4_q  <= pcplus4F;
         valid_q <= validF;
      end
   end

   // Sticky flag ignores stall/flush; only reset clears it.
   assign seen_d = seen_q | illegalD;

   always_ff @(posedge clk) begin
      if (reset) seen_q <= 1'b0;
      else       seen_q <= seen_d;
   end

   if_id_decode_stage_main_decoder u_dec (
      .opcode_i (instr_q[6:0]),
      .ctrl_o   (ctrl)
   );

   assign illegalD = valid_q & ~ctrl.known;
   assign live     = valid_q & ~illegalD;

   assign instrD       = instr_q;
   assign pcD          = pc_q;
   assign pcplus4D     = pcp4_q;
   assign validD       = valid_q;
   assign illegal_seen = seen_q;

   assign immsrcD    = ctrl.immsrc;
   assign resultsrcD = ctrl.resultsrc;
   assign alusrcD    = ctrl.alusrc;
   assign alusrcaD   = ctrl.alusrca;
   assign aluopD     = ctrl.aluop;
   assign regwriteD  = ctrl.regwrite & live;
   assign memwriteD  = ctrl.memwrite & live;
   assign branchD    = ctrl.branch & live;
   assign jumpD      = ctrl.jump & live;
   assign jalrD      = ctrl.jalr & live;

   assign rs1D = instr_q[19:15];
   assign rs2D = instr_q[24:20];
   assign rdD  = instr_q[11:7];

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Self-checking bench for the IF/ID register and main decoder.
// Table vectors go through a scoreboard queue; corner cases are hand sequenced.
module tb_if_id_decode_stage;

   logic        clk = 1'b0;
   logic        reset, validF, stallD, flushD;
   logic [31:0] instrF, pcF, pcplus4F;
   logic [31:0] instrD, pcD, pcplus4D;
   logic        validD, regwriteD, memwriteD, branchD, jumpD, jalrD;
   logic        alusrcD, illegalD, illegal_seen;
   logic [2:0]  immsrcD;
   logic [1:0]  resultsrcD, alusrcaD, aluopD;
   logic [4:0]  rs1D, rs2D, rdD;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   if_id_decode_stage dut (
      .clk(clk), .reset(reset), .instrF(instrF), .pcF(pcF),
      .pcplus4F(pcplus4F), .validF(validF), .stallD(stallD),
      .flushD(flushD), .instrD(instrD), .pcD(pcD),
      .pcplus4D(pcplus4D), .validD(validD), .immsrcD(immsrcD),
      .regwriteD(regwriteD), .resultsrcD(resultsrcD),
      .memwriteD(memwriteD), .branchD(branchD), .jumpD(jumpD),
      .jalrD(jalrD), .alusrcD(alusrcD), .alusrcaD(alusrcaD),
      .aluopD(aluopD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
      .illegalD(illegalD), .illegal_seen(illegal_seen)
   );

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic [2:0]  imm;
      logic        rw;
      logic [1:0]  rsrc;
      logic        mw, br, j, jr, asrc;
      logic [1:0]  asrca, aop;
      logic        ill, seen;
      logic [31:0] pc;
   } vec_t;

   vec_t vt[12];
   vec_t sbq[$];
   vec_t e;

   function automatic vec_t mk(
      logic [31:0] instr, logic valid, logic [2:0] imm, logic rw,
      logic [1:0] rsrc, logic mw, logic br, logic j, logic jr,
      logic asrc, logic [1:0] asrca, logic [1:0] aop,
      logic ill, logic seen);
      vec_t v;
      v.instr = instr; v.valid = valid; v.imm = imm; v.rw = rw;
      v.rsrc = rsrc; v.mw = mw; v.br = br; v.j = j; v.jr = jr;
      v.asrc = asrc; v.asrca = asrca; v.aop = aop;
      v.ill = ill; v.seen = seen; v.pc = 32'h0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic v,
                        input logic [31:0] pc);
      @(negedge clk);
      instrF = ins; validF = v; pcF = pc; pcplus4F = pc + 32'd4;
   endtask

   initial begin
      //        instr         v  imm   rw rsrc  mw br j jr as asa   aop  il sn
      vt[0]  = mk(32'h00500093,1,3'd0,1,2'b00,0,0,0,0,1,2'b00,2'b10,0,0);
      vt[1]  = mk(32'h0020A423,1,3'd1,0,2'b00,1,0,0,0,1,2'b00,2'b00,0,0);
      vt[2]  = mk(32'h002081B3,1,3'd0,1,2'b00,0,0,0,0,0,2'b00,2'b10,0,0);
      vt[3]  = mk(32'h00208463,1,3'd2,0,2'b00,0,1,0,0,0,2'b00,2'b01,0,0);
      vt[4]  = mk(32'h123452B7,1,3'd4,1,2'b00,0,0,0,0,1,2'b10,2'b00,0,0);
      vt[5]  = mk(32'h000000EF,1,3'd3,1,2'b10,0,0,1,0,0,2'b00,2'b00,0,0);
      vt[6]  = mk(32'h000100E7,1,3'd0,1,2'b10,0,0,1,1,1,2'b00,2'b00,0,0);
      vt[7]  = mk(32'h0040A203,1,3'd0,1,2'b01,0,0,0,0,1,2'b00,2'b00,0,0);
      vt[8]  = mk(32'h00001317,1,3'd4,1,2'b00,0,0,0,0,1,2'b01,2'b00,0,0);
      vt[9]  = mk(32'h00500093,0,3'd0,0,2'b00,0,0,0,0,1,2'b00,2'b10,0,0);
      vt[10] = mk(32'hFFFFFFFF,0,3'd0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,0);
      vt[11] = mk(32'hFFFFFFFF,1,3'd0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,0);

      reset = 1; validF = 1; stallD = 0; flushD = 0;
      instrF = 32'h00500093; pcF = 32'h40; pcplus4F = 32'h44;
      tick(); tick();
      chk("rst_instr", instrD, 32'h13);
      chk("rst_valid", {31'b0, validD}, 0);
      chk("rst_pc", pcD, 0);
      chk("rst_rw", {31'b0, regwriteD}, 0);
      chk("rst_seen", {31'b0, illegal_seen}, 0);
      @(negedge clk) reset = 0;

      for (int i = 0; i < 12; i++) begin
         e = vt[i];
         e.pc = 32'h100 + 32'(i) * 32'd4;
         drive(e.instr, e.valid, e.pc);
         sbq.push_back(e);
         tick();
         e = sbq.pop_front();
         chk($sformatf("v%0d_instr", i), instrD, e.instr);
         chk($sformatf("v%0d_pc", i), pcD, e.pc);
         chk($sformatf("v%0d_pc4", i), pcplus4D, e.pc + 32'd4);
         chk($sformatf("v%0d_valid", i), {31'b0, validD}, {31'b0, e.valid});
         chk($sformatf("v%0d_ctl", i),
             {18'b0, immsrcD, regwriteD, resultsrcD, memwriteD, branchD,
              jumpD, jalrD, alusrcD, alusrcaD, aluopD},
             {18'b0, e.imm, e.rw, e.rsrc, e.mw, e.br,
              e.j, e.jr, e.asrc, e.asrca, e.aop});
         chk($sformatf("v%0d_regs", i), {17'b0, rs1D, rs2D, rdD},
             {17'b0, e.instr[19:15], e.instr[24:20], e.instr[11:7]});
         chk($sformatf("v%0d_ill", i), {31'b0, illegalD}, {31'b0, e.ill});
         chk($sformatf("v%0d_seen", i), {31'b0, illegal_seen},
             {31'b0, e.seen});
      end

      drive(32'h00000013, 1, 32'h200);
      tick();
      chk("seen_set", {31'b0, illegal_seen}, 1);
      @(negedge clk) flushD = 1;
      tick();
      chk("flush_instr", instrD, 32'h13);
      chk("flush_valid", {31'b0, validD}, 0);
      chk("seen_thru_flush", {31'b0, illegal_seen}, 1);
      @(negedge clk) flushD = 0;

      drive(32'h0020A423, 1, 32'h300);
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         stallD = 1; instrF = 32'h00700093 + 32'(k); pcF = 32'h400;
         tick();
         chk($sformatf("stall%0d_instr", k), instrD, 32'h0020A423);
         chk($sformatf("stall%0d_pc", k), pcD, 32'h300);
         chk($sformatf("stall%0d_imm", k), {29'b0, immsrcD}, 1);
         chk($sformatf("stall%0d_mw", k), {31'b0, memwriteD}, 1);
         chk($sformatf("stall%0d_rw", k), {31'b0, regwriteD}, 0);
      end

      @(negedge clk);
      instrF = 32'h00208463; validF = 1; stallD = 1; flushD = 1;
      tick();
      chk("sf_instr", instrD, 32'h13);
      chk("sf_valid", {31'b0, validD}, 0);
      chk("sf_br", {31'b0, branchD}, 0);

      @(negedge clk) flushD = 0;
      reset = 1;
      tick();
      chk("rst_stall_instr", instrD, 32'h13);
      chk("rst_stall_seen", {31'b0, illegal_seen}, 0);
      @(negedge clk) reset = 0;

      instrF = 32'hFFFFFFFF; validF = 1; stallD = 0;
      tick();
      chk("ill_v1", {31'b0, illegalD}, 1);
      @(negedge clk) stallD = 1;
      tick();
      chk("seen_in_stall", {31'b0, illegal_seen}, 1);
      chk("ill_hold_rw", {31'b0, regwriteD | memwriteD | jumpD}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/if_id_decode_stage.md
Name: if_id_decode_stage

Overview:
- Fetch/decode boundary of the 5-stage RV32I pipeline: IF/ID pipeline register plus main decoder.
- Latches fetched instruction and PC state with stall/flush control.
- Decodes the registered instruction into D-stage controls, including immsrcD[2:0] and instrD[31:7] for the immediate extender, and register indices for the hazard unit and register file.

Parameters:
- XLEN, 32, datapath/PC width
- NOP_INSTR, 32'h00000013, value loaded on reset/flush (addi x0,x0,0)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high
- instrF  input  32  fetched instruction
- pcF  input  XLEN  fetch PC
- pcplus4F  input  XLEN  fetch PC+4
- validF  input  1  fetch slot holds a real instruction
- stallD  input  1  hold IF/ID contents
- flushD  input  1  replace IF/ID contents with bubble
- instrD  output  32  registered instruction; [31:7] drives extender
- pcD  output  XLEN  registered PC
- pcplus4D  output  XLEN  registered PC+4
- validD  output  1  D slot valid
- immsrcD  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- regwriteD  output  1  write rd
- resultsrcD  output  2  00 ALU, 01 memory, 10 PC+4
- memwriteD  output  1  store
- branchD  output  1  conditional branch
- jumpD  output  1  jal/jalr
- jalrD  output  1  jalr (target from rs1)
- alusrcD  output  1  ALU B operand: 0 rs2, 1 immediate
- alusrcaD  output  2  ALU A operand: 00 rs1, 01 PC (auipc), 10 zero (lui)
- aluopD  output  2  00 add, 01 sub/compare, 10 funct-decoded
- rs1D, rs2D, rdD  output  5 each  instrD[19:15], [24:20], [11:7]
- illegalD  output  1  valid slot with unsupported opcode
- illegal_seen  output  1  sticky; set on any illegalD, cleared only by reset

Behaviour:
- Register update priority on posedge clk: reset > flushD > stallD > load.
- reset or flushD: instrD=NOP_INSTR, pcD=0, pcplus4D=0, validD=0. reset also clears illegal_seen.
- flushD with stallD in the same cycle: flush wins.
- stallD alone: all IF/ID registers hold; illegal_seen unaffected.
- Otherwise: instrD<=instrF, pcD<=pcF, pcplus4D<=pcplus4F, validD<=validF.
- Latency: 1 cycle F→D. All decode outputs are combinational from the registered state; no extra delay.
- Decode by instrD[6:0]. Listed flags are 1; all others 0.
  - 0000011 load: immsrc 000, regwrite, resultsrc 01, alusrc, aluop 00
  - 0100011 store: immsrc 001, memwrite, alusrc, aluop 00
  - 0110011 R-type: regwrite, aluop 10
  - 0010011 I-ALU: immsrc 000, regwrite, alusrc, aluop 10
  - 1100011 branch: immsrc 010, branch, aluop 01
  - 1101111 jal: immsrc 011, regwrite, jump, resultsrc 10
  - 1100111 jalr: immsrc 000, regwrite, jump, jalr, alusrc, resultsrc 10, aluop 00
  - 0110111 lui: immsrc 100, regwrite, alusrc, alusrca 10, aluop 00
  - 0010111 auipc: immsrc 100, regwrite, alusrc, alusrca 01, aluop 00
- Unknown opcode: immsrc 000, all flags 0; illegalD = validD.
- Gating: when validD=0 or illegalD=1, force regwriteD, memwriteD, branchD, jumpD, jalrD to 0. immsrcD and rs/rd fields still decode from instrD.
- illegal_seen: set on the posedge following any cycle with illegalD=1; it sets even if stallD is asserted that cycle.
- Reset mid-stall or mid-flush: reset result only; no stale state.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - IMM_I/S/B/J/U encodings (3-bit) shared with the extender
  - RESULT_* and ALUOP_* encodings
  - NOP_INSTR
- One natural sub-module: main_decoder (purely combinational, opcode → control bundle), instantiated beneath the IF/ID register.

Test Plan:
- reset=1 for 2 cycles, validF=1, instrF=0x00500093 → instrD=0x00000013, validD=0, regwriteD=0, illegal_seen=0.
- Load addi x1,x0,5 (0x00500093) → next cycle: immsrcD=000, regwriteD=1, alusrcD=1, aluopD=10, rdD=1, rs1D=0.
- sw x2,8(x1) (0x0020A423), then stallD=1 for 3 cycles with instrF changing → instrD holds 0x0020A423; immsrcD=001, memwriteD=1, regwriteD=0.
- beq x1,x2,8 (0x00208463) with stallD=1 and flushD=1 asserted together → instrD=NOP, validD=0, branchD=0.
- Sequence lui x5,0x12345 (0x123452B7), jal x1,0 (0x000000EF) → immsrcD=100 with alusrcaD=10; then immsrcD=011, jumpD=1, resultsrcD=10.
- instrF=0xFFFFFFFF with validF=1 → illegalD=1 and all writes 0; illegal_seen=1 next cycle and stays set through a flush. With validF=0 the same word gives illegalD=0.
